// File: rtl/mem_responder.sv
// Fixed-latency instruction/data memory model: one FSM per port over a shared word array.
// Latency: IMEM_LATENCY/DMEM_LATENCY cycles from sample to resp; no backpressure, requests are ignored outside IDLE.
module mem_responder_port #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] word,
  output logic        sample,
  output logic [31:0] rdata,
  output logic        resp
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap;

  // Gated by rst so nothing commits to the array while reset is held.
  assign sample = rst && (state == IDLE) && req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cap   <= 32'd0;
      rdata <= 32'd0;
      resp  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap <= word;
            cnt <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state <= RESP;
              resp  <= 1'b1;
              rdata <= word;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            resp  <= 1'b1;
            rdata <= cap;
          end
        end
        RESP: begin
          state <= IDLE;
          resp  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          resp  <= 1'b0;
        end
      endcase
    end
  end

endmodule

module mem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int IMEM_LATENCY = 1,
  parameter int DMEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] imem_idx;
  logic [AW-1:0] dmem_idx;
  logic [31:0]   imem_word;
  logic [31:0]   dmem_word;
  logic          imem_sample;
  logic          dmem_sample;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign imem_idx = imem_addr[AW+1:2];
  assign dmem_idx = dmem_addr[AW+1:2];

  logic unused_addr;
  assign unused_addr = &{1'b0, imem_addr[31:AW+2], imem_addr[1:0],
                         dmem_addr[31:AW+2], dmem_addr[1:0], imem_sample};

  assign imem_word = mem[imem_idx];
  assign dmem_word = mem[dmem_idx];

  mem_responder_port #(.LATENCY(IMEM_LATENCY)) u_imem (
    .clk    (clk),
    .rst    (rst),
    .req    (|imem_rmask),
    .word   (imem_word),
    .sample (imem_sample),
    .rdata  (imem_rdata),
    .resp   (imem_resp)
  );

  mem_responder_port #(.LATENCY(DMEM_LATENCY)) u_dmem (
    .clk    (clk),
    .rst    (rst),
    .req    ((|dmem_rmask) || (|dmem_wmask)),
    .word   (dmem_word),
    .sample (dmem_sample),
    .rdata  (dmem_rdata),
    .resp   (dmem_resp)
  );

  // Array is not reset; both ports read the pre-write word on the commit edge.
  always_ff @(posedge clk) begin
    if (dmem_sample) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wmask[b]) mem[dmem_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters (1024 words, imem latency 1, dmem latency 2).
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one dmem access; lat = number of negedges after the sample edge until resp (-1 on timeout).
  task automatic dmem_op(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd);
    @(negedge clk);
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    dmem_rmask = 4'h0; dmem_wmask = 4'h0;
    lat = -1; rd = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      if (dmem_resp) begin
        lat = k; rd = dmem_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic imem_op(input logic [31:0] a, output int lat, output logic [31:0] rd);
    @(negedge clk);
    imem_addr = a; imem_rmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    imem_rmask = 4'h0;
    lat = -1; rd = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      if (imem_resp) begin
        lat = k; rd = imem_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_addr = 32'h0; imem_rmask = 4'h0;
    dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_resp !== 1'b0) begin n_err++; $display("FAIL reset_imem_resp got %0b want 0", imem_resp); end
    n_cmp++; if (dmem_resp !== 1'b0) begin n_err++; $display("FAIL reset_dmem_resp got %0b want 0", dmem_resp); end
    n_cmp++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_imem_rdata got %h want 00000000", imem_rdata); end
    n_cmp++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dmem_rdata got %h want 00000000", dmem_rdata); end
    rst = 1'b1;
  endtask

  task automatic test_latency();
    int lat; logic [31:0] rd;
    dmem_op(32'h40, 4'h0, 4'hF, 32'hDEADBEEF, lat, rd);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL dmem_write_latency got %0d want 2", lat); end
    @(negedge clk);
    n_cmp++; if (dmem_resp !== 1'b0) begin n_err++; $display("FAIL dmem_resp_one_cycle got %0b want 0", dmem_resp); end
    dmem_op(32'h40, 4'hF, 4'h0, 32'h0, lat, rd);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL dmem_read_latency got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL dmem_read_back got %h want deadbeef", rd); end
    imem_op(32'h40, lat, rd);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL imem_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL imem_read_back got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_lane();
    int lat; logic [31:0] rd;
    dmem_op(32'h40, 4'h0, 4'h1, 32'h00000055, lat, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_only_prewrite got %h want deadbeef", rd); end
    dmem_op(32'h40, 4'h1, 4'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'hDEADBE55) begin n_err++; $display("FAIL byte_lane0 got %h want deadbe55", rd); end
    dmem_op(32'h40, 4'hF, 4'hA, 32'hA1B2C3D4, lat, rd);
    n_cmp++; if (rd !== 32'hDEADBE55) begin n_err++; $display("FAIL combined_old_word got %h want deadbe55", rd); end
    dmem_op(32'h42, 4'hF, 4'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'hA1ADC355) begin n_err++; $display("FAIL byte_lanes_3_1 got %h want a1adc355", rd); end
  endtask

  task automatic test_conflict();
    int lat; logic [31:0] rd;
    dmem_op(32'h80, 4'h0, 4'hF, 32'h0, lat, rd);
    @(negedge clk);
    imem_addr = 32'h80; imem_rmask = 4'hF;
    dmem_addr = 32'h80; dmem_wmask = 4'hF; dmem_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    imem_rmask = 4'h0; dmem_wmask = 4'h0;
    n_cmp++; if (imem_resp !== 1'b1) begin n_err++; $display("FAIL conflict_imem_resp got %0b want 1", imem_resp); end
    n_cmp++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL conflict_imem_prewrite got %h want 00000000", imem_rdata); end
    @(negedge clk);
    n_cmp++; if (dmem_resp !== 1'b1) begin n_err++; $display("FAIL conflict_dmem_resp got %0b want 1", dmem_resp); end
    imem_op(32'h80, lat, rd);
    n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL conflict_imem_after got %h want 12345678", rd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_rdata !== 32'h12345678) begin n_err++; $display("FAIL imem_rdata_hold got %h want 12345678", imem_rdata); end
  endtask

  task automatic test_input_change();
    int lat; logic [31:0] rd;
    @(negedge clk);
    dmem_addr = 32'h40; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
    @(posedge clk);
    @(negedge clk);
    dmem_addr = 32'h80; dmem_rmask = 4'h0; dmem_wmask = 4'hF; dmem_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_cmp++; if (dmem_resp !== 1'b1) begin n_err++; $display("FAIL wait_change_resp got %0b want 1", dmem_resp); end
    n_cmp++; if (dmem_rdata !== 32'hA1ADC355) begin n_err++; $display("FAIL wait_change_rdata got %h want a1adc355", dmem_rdata); end
    dmem_wmask = 4'h0;
    dmem_op(32'h80, 4'hF, 4'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL wait_change_no_write got %h want 12345678", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd;
    dmem_op(32'h1004, 4'h0, 4'hF, 32'hCAFEF00D, lat, rd);
    dmem_op(32'h0004, 4'hF, 4'h0, 32'h0, lat, rd);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL addr_wrap got %h want cafef00d", rd); end
    imem_op(32'hFFFF_F007, lat, rd);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL imem_wrap_offset got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pat;
    @(negedge clk);
    imem_addr = 32'h40; imem_rmask = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = imem_resp;
    end
    imem_rmask = 4'h0;
    n_cmp++; if (pat !== 12'h555) begin n_err++; $display("FAIL back_to_back_pattern got %h want 555", pat); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [31:0] rd;
    logic seen;
    @(negedge clk);
    dmem_addr = 32'h100; dmem_wmask = 4'hF; dmem_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    dmem_wmask = 4'h0;
    rst = 1'b0;
    #1;
    n_cmp++; if (dmem_resp !== 1'b0) begin n_err++; $display("FAIL midreset_resp got %0b want 0", dmem_resp); end
    n_cmp++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL midreset_dmem_rdata got %h want 00000000", dmem_rdata); end
    n_cmp++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL midreset_imem_rdata got %h want 00000000", imem_rdata); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dmem_resp) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_resp got %0b want 0", seen); end
    dmem_op(32'h100, 4'hF, 4'h0, 32'h0, lat, rd);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL post_reset_latency got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL committed_write_kept got %h want 0badf00d", rd); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_lane();
    test_conflict();
    test_input_change();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
